// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between the
// I-cache and D-cache; serves one line transaction at a time.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 0 = I-cache, 1 = D-cache
  logic   i_pend, d_pend;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state signal gets a default before the case,
    // so no path leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_addr    = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;

    case (state_q)
      IDLE: begin
        // On a tie the side that was not granted last time wins.
        if (d_pend && (!i_pend || !last_grant_q)) begin
          state_d      = SERVE_D;
          last_grant_d = 1'b1;
        end else if (i_pend) begin
          state_d      = SERVE_I;
          last_grant_d = 1'b0;
        end
      end

      SERVE_I: begin
        pmem_read = 1'b1;
        pmem_addr = i_addr;
        // A response landing during reset belongs to an aborted system state.
        if (pmem_resp && !rst) begin
          i_resp  = 1'b1;
          i_rdata = pmem_rdata;
        end
        if (pmem_resp) state_d = IDLE;
      end

      SERVE_D: begin
        pmem_addr = d_addr;
        if (d_write) begin
          pmem_write = 1'b1;
          pmem_wdata = d_wdata;
        end else begin
          pmem_read = 1'b1;
        end
        if (pmem_resp && !rst) begin
          d_resp  = 1'b1;
          d_rdata = pmem_rdata;
        end
        if (pmem_resp) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus random
// traffic, checked every cycle against a transaction-level ownership model.
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, pmem_resp;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, pmem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_addr;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Requester-side intent
  bit                rand_mode = 0, spurious_en = 0, force_resp = 0, rst_v = 0;
  bit                i_pend = 0, i_cool = 0, d_pend = 0, d_cool = 0, d_wr = 0, d_rd = 0;
  logic [ADDR_W-1:0] i_addr_v = '0, d_addr_v = '0;
  logic [LINE_W-1:0] d_wdata_v = '0, fixed_line = '0;

  // Memory model
  bit mem_active = 0;
  int mem_cnt = 0, mem_lat = 3;

  // Reference model: who owns the memory port (0 none, 1 I, 2 D) and who was served last
  int owner = 0;
  bit last_d = 0;

  // Observation log
  int                cycle = 0, n_iresp = 0, n_dresp = 0;
  bit                prev_cmd = 0;
  logic [ADDR_W-1:0] grant_q[$];
  int                start_q[$];

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    logic              exp_rd, exp_wr, exp_ir, exp_dr, ip, dp;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wdata;
    @(negedge clk);
    if (rand_mode) begin
      if (!i_pend && !i_cool && owner != 1 && $urandom_range(0, 3) == 0) begin
        i_pend = 1; i_addr_v = $urandom & 32'hffff_ffe0;
      end
      if (!d_pend && !d_cool && owner != 2 && $urandom_range(0, 3) == 0) begin
        d_pend = 1; d_wr = 1'($urandom_range(0, 1));
        d_rd = !d_wr || ($urandom_range(0, 1) == 1);
        d_addr_v = $urandom & 32'hffff_ffe0; d_wdata_v = rand_line();
      end
      // Occasional protocol violation: request dropped mid-transaction
      if (i_pend && owner == 1 && $urandom_range(0, 63) == 0) i_pend = 0;
      if (d_pend && owner == 2 && $urandom_range(0, 63) == 0) d_pend = 0;
      rst_v = ($urandom_range(0, 199) == 0);
    end
    i_cool = 0; d_cool = 0;
    rst = rst_v;
    i_read = i_pend; i_addr = i_addr_v;
    d_read = d_pend && d_rd; d_write = d_pend && d_wr;
    d_addr = d_addr_v; d_wdata = d_wdata_v;
    pmem_resp = 1'b0;
    pmem_rdata = rand_mode ? rand_line() : fixed_line;
    #1;
    exp_rd    = (owner == 1) || (owner == 2 && !d_write);
    exp_wr    = (owner == 2) && d_write;
    exp_addr  = (owner == 1) ? i_addr : (owner == 2) ? d_addr : '0;
    exp_wdata = exp_wr ? d_wdata : '0;
    check("pmem_read", LINE_W'(pmem_read), LINE_W'(exp_rd));
    check("pmem_write", LINE_W'(pmem_write), LINE_W'(exp_wr));
    check("pmem_addr", LINE_W'(pmem_addr), LINE_W'(exp_addr));
    check("pmem_wdata", pmem_wdata, exp_wdata);
    if ((pmem_read || pmem_write) && !prev_cmd) begin
      grant_q.push_back(pmem_addr); start_q.push_back(cycle);
    end
    prev_cmd = pmem_read || pmem_write;
    if (mem_active) begin
      mem_cnt--;
      if (mem_cnt == 0) begin pmem_resp = 1'b1; mem_active = 0; end
    end else if (pmem_read || pmem_write) begin
      mem_active = 1; mem_cnt = rand_mode ? $urandom_range(1, 4) : mem_lat;
    end else if (force_resp || (spurious_en && $urandom_range(0, 9) == 0)) begin
      pmem_resp = 1'b1;
    end
    #1;
    exp_ir = (owner == 1) && pmem_resp && !rst;
    exp_dr = (owner == 2) && pmem_resp && !rst;
    check("i_resp", LINE_W'(i_resp), LINE_W'(exp_ir));
    check("d_resp", LINE_W'(d_resp), LINE_W'(exp_dr));
    if (exp_ir || owner != 1) check("i_rdata", i_rdata, exp_ir ? pmem_rdata : '0);
    if (exp_dr || owner != 2) check("d_rdata", d_rdata, exp_dr ? pmem_rdata : '0);
    n_iresp += int'(i_resp); n_dresp += int'(d_resp);
    if (exp_ir) begin i_pend = 0; i_cool = 1; end
    if (exp_dr) begin d_pend = 0; d_cool = 1; end
    if (rst) begin i_pend = 0; d_pend = 0; end
    // Ownership rules: served side finishes on pmem_resp; IDLE picks the
    // pending side, alternating on a tie.
    ip = i_read; dp = d_read || d_write;
    if (rst) begin
      owner = 0; last_d = 0;
    end else if (owner != 0) begin
      if (pmem_resp) owner = 0;
    end else if (ip || dp) begin
      owner  = (ip && dp) ? (last_d ? 1 : 2) : (ip ? 1 : 2);
      last_d = (owner == 2);
    end
    cycle++;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 60 && !(owner == 0 && !i_pend && !d_pend && !mem_active); n++) step();
    check(tag, LINE_W'(owner == 0 && !i_pend && !d_pend && !mem_active), LINE_W'(1));
  endtask

  task automatic do_reset();
    rst_v = 1; step(); step(); rst_v = 0;
    mem_active = 0;
    grant_q.delete(); start_q.delete();
  endtask

  int base_i, base_d, d_cnt;

  initial begin
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;

    // 1: reset then single I read, memory latency 3, line of 0xA5
    fixed_line = {(LINE_W / 8){8'hA5}};
    mem_lat = 3;
    do_reset();
    base_i = n_iresp; base_d = n_dresp;
    i_pend = 1; i_addr_v = 32'h0000_0060;
    step();
    check("t1_grant_latency", LINE_W'(start_q.size()), LINE_W'(0));
    step();
    check("t1_cmd_next_cycle", LINE_W'(start_q.size()), LINE_W'(1));
    drain("t1_drain");
    check("t1_i_resp_once", LINE_W'(n_iresp - base_i), LINE_W'(1));
    check("t1_no_d_resp", LINE_W'(n_dresp - base_d), LINE_W'(0));

    // 2: simultaneous I and D after reset -> D first, one IDLE cycle, then I
    do_reset();
    i_pend = 1; i_addr_v = 32'h100;
    d_pend = 1; d_rd = 1; d_wr = 0; d_addr_v = 32'h200;
    drain("t2_drain");
    check("t2_first", LINE_W'(grant_q.size() > 0 ? grant_q[0] : '1), LINE_W'(32'h200));
    check("t2_second", LINE_W'(grant_q.size() > 1 ? grant_q[1] : '1), LINE_W'(32'h100));
    check("t2_gap", LINE_W'(start_q.size() > 1 ? start_q[1] - start_q[0] : -1),
          LINE_W'(mem_lat + 2));

    // 3: D re-requests continuously while I holds 0x400 -> D, I, D
    grant_q.delete(); start_q.delete();
    d_cnt = 0;
    i_pend = 1; i_addr_v = 32'h400;
    for (int n = 0; n < 40; n++) begin
      if (!d_pend && !d_cool && d_cnt < 3) begin
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr_v = 32'h300 + 32'(d_cnt * 32); d_cnt++;
      end
      step();
    end
    drain("t3_drain");
    check("t3_g0", LINE_W'(grant_q.size() > 0 ? grant_q[0] : '1), LINE_W'(32'h300));
    check("t3_g1", LINE_W'(grant_q.size() > 1 ? grant_q[1] : '1), LINE_W'(32'h400));
    check("t3_g2", LINE_W'(grant_q.size() > 2 ? grant_q[2] : '1), LINE_W'(32'h320));

    // 4: D write-back with d_read also high -> write wins
    grant_q.delete(); start_q.delete();
    base_d = n_dresp;
    d_pend = 1; d_rd = 1; d_wr = 1; d_addr_v = 32'h80; d_wdata_v = {(LINE_W / 8){8'h5A}};
    step(); step();
    check("t4_write", LINE_W'(pmem_write), LINE_W'(1));
    check("t4_read", LINE_W'(pmem_read), LINE_W'(0));
    check("t4_wdata", pmem_wdata, {(LINE_W / 8){8'h5A}});
    drain("t4_drain");
    check("t4_d_resp", LINE_W'(n_dresp - base_d), LINE_W'(1));

    // 5: reset two cycles into an I transaction; late resp ignored; tie -> D
    do_reset();
    mem_lat = 4;
    base_i = n_iresp; base_d = n_dresp;
    i_pend = 1; i_addr_v = 32'h500;
    step(); step(); step();
    rst_v = 1; step(); rst_v = 0;
    step();
    check("t5_cmd_dropped", LINE_W'(pmem_read), LINE_W'(0));
    for (int n = 0; n < 4; n++) step();
    check("t5_no_i_resp", LINE_W'(n_iresp - base_i), LINE_W'(0));
    check("t5_no_d_resp", LINE_W'(n_dresp - base_d), LINE_W'(0));
    grant_q.delete(); start_q.delete();
    i_pend = 1; i_addr_v = 32'h600;
    d_pend = 1; d_rd = 1; d_wr = 0; d_addr_v = 32'h700;
    drain("t5_drain");
    check("t5_tie_to_d", LINE_W'(grant_q.size() > 0 ? grant_q[0] : '1), LINE_W'(32'h700));

    // 6: spurious pmem_resp in IDLE with no requests
    base_i = n_iresp; base_d = n_dresp;
    force_resp = 1; step(); force_resp = 0;
    step();
    check("t6_no_resp", LINE_W'((n_iresp - base_i) + (n_dresp - base_d)), LINE_W'(0));
    check("t6_stay_idle", LINE_W'(pmem_read || pmem_write), LINE_W'(0));

    // Random traffic with random latency, resets and spurious responses
    rand_mode = 1; spurious_en = 1;
    for (int n = 0; n < 3000; n++) step();
    rand_mode = 0; spurious_en = 0; rst_v = 0;
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
